hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits directly downstream of the register file and consumes its two read ports (rs on A, rt on B) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Its Hi/Lo outputs feed the write-back mux that drives the register file's WriteData for MFHI/MFLO. Control stalls issue while Busy is high.

---
 rtl/hilo_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 multiply / 32/32 divide unit holding the
// architectural HI/LO registers.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high reset
//   Start      launch the operation selected by Op (sampled only in IDLE)
//   Op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B       rs / rt operands; latched at the Start edge
//   Mthi/Mtlo  copy A into HI / LO (honoured only in IDLE without Start)
//   Busy       high while an operation is in flight
//   Done       one-cycle pulse after HI/LO have been updated
//   DivByZero  one-cycle pulse together with Done for a divide by zero
//   Hi, Lo     HI / LO registers
//
// Both operations work on magnitudes. The low half of the accumulator
// starts as |A|: for a multiply it is the multiplier being shifted out,
// and for a divide it is the dividend being shifted into the remainder
// while quotient bits shift in behind it. |B| is the multiplicand or the
// divisor. Signs are restored in the FIX state.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Mthi,
  input  logic             Mtlo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  // Two's complement negation helpers used for operand magnitude and
  // for the final sign correction.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
    return -x;
  endfunction

  // Control state
  state_t           r_state;
  logic [5:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Datapath state (no reset needed; always loaded at Start)
  logic             r_is_div;
  logic             r_sa;
  logic             r_sb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_opnd;

  // Operand magnitudes; only the signed ops (Op[0]=1) take magnitudes.
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // Iteration datapath
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  // Sign-corrected results
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  assign w_sa    = Op[0] & A[WIDTH-1];
  assign w_sb    = Op[0] & B[WIDTH-1];
  assign w_abs_a = w_sa ? neg_w(A) : A;
  assign w_abs_b = w_sb ? neg_w(B) : B;

  // Multiply step: add multiplicand to the upper half when the multiplier
  // LSB is set; the carry becomes the new MSB after the right shift.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};

  // Divide step: 33-bit partial remainder after shifting in the next
  // dividend bit. When it is >= divisor the difference fits in WIDTH bits,
  // so the subtraction only needs the low WIDTH bits.
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd});
  assign w_sub   = w_shift[WIDTH-1:0] - r_opnd;

  assign w_prod = (r_sa ^ r_sb) ? neg_d(r_acc) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rmd  = r_sa ? neg_w(r_rem) : r_rem;

  // Control FSM and architectural HI/LO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            // Start takes priority over a simultaneous move.
            r_cnt  <= 6'd0;
            r_busy <= 1'b1;
            if (Op[1] && (B == '0)) r_state <= S_ZERO;
            else                    r_state <= S_RUN;
          end else begin
            if (Mthi) r_hi <= A;
            if (Mtlo) r_lo <= A;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ZERO: begin
          r_done  <= 1'b1;
          r_dbz   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Iterative datapath
  always_ff @(posedge Clk) begin
    if (r_state == S_IDLE) begin
      if (Start) begin
        r_is_div <= Op[1];
        r_sa     <= w_sa;
        r_sb     <= w_sb;
        r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
        r_opnd   <= w_abs_b;
        r_rem    <= '0;
      end
    end else if (r_state == S_RUN) begin
      if (r_is_div) begin
        r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign Hi        = r_hi;
  assign Lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases followed by random
// operations, compared against a plain-arithmetic model of HI/LO.
module tb_hilo_muldiv;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Mthi;
  logic        Mtlo;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks   = 0;
  int failures = 0;

  // Architectural HI/LO as the model expects them
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Mthi(Mthi), .Mtlo(Mtlo), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics computed with 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dz);
    longint sa, sb, p, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
      2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) dz = 1'b1;
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else begin p = sa / sb; r = sa % sb; lo = p[31:0]; hi = r[31:0]; end
      end
    endcase
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mh, input logic ml);
    @(negedge Clk);
    Op = op; A = a; B = b; Start = 1'b1; Mthi = mh; Mtlo = ml;
    @(negedge Clk);
    Start = 1'b0; Mthi = 1'b0; Mtlo = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  // Called after E(lat0); waits for Done within a bounded budget.
  task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat0);
    logic [31:0] ehi, elo;
    logic dz;
    int lat;
    logic busy_ok;
    model(op, a, b, ehi, elo, dz);
    if (dz) begin
      chk1({tag, "_dz_busy"}, Busy, 1'b1);
      chk1({tag, "_dz_nodone"}, Done, 1'b0);
      @(negedge Clk);
      chk1({tag, "_dz_done"}, Done, 1'b1);
      chk1({tag, "_dz_flag"}, DivByZero, 1'b1);
      chk1({tag, "_dz_idle"}, Busy, 1'b0);
      chk({tag, "_dz_hi"}, Hi, mhi);
      chk({tag, "_dz_lo"}, Lo, mlo);
      @(negedge Clk);
      chk1({tag, "_dz_pulse"}, Done, 1'b0);
    end else begin
      lat = lat0;
      busy_ok = 1'b1;
      while (!Done && lat < 40) begin
        if (!Busy) busy_ok = 1'b0;
        @(negedge Clk);
        lat++;
      end
      chk({tag, "_latency"}, lat, 33);
      chk1({tag, "_busy_run"}, busy_ok, 1'b1);
      chk1({tag, "_busy_end"}, Busy, 1'b0);
      chk1({tag, "_nodz"}, DivByZero, 1'b0);
      chk({tag, "_hi"}, Hi, ehi);
      chk({tag, "_lo"}, Lo, elo);
      mhi = ehi;
      mlo = elo;
      @(negedge Clk);
      chk1({tag, "_pulse"}, Done, 1'b0);
    end
  endtask

  task automatic do_move(input logic mh, input logic ml, input logic [31:0] val);
    @(negedge Clk);
    Mthi = mh; Mtlo = ml; A = val;
    @(negedge Clk);
    Mthi = 1'b0; Mtlo = 1'b0; A = $urandom;
    if (mh) mhi = val;
    if (ml) mlo = val;
    chk("move_hi", Hi, mhi);
    chk("move_lo", Lo, mlo);
    chk1("move_busy", Busy, 1'b0);
    chk1("move_done", Done, 1'b0);
  endtask

  initial begin
    int dcount;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0; Mthi = 1'b0; Mtlo = 1'b0;
    repeat (2) @(negedge Clk);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_dbz", DivByZero, 1'b0);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    Reset = 1'b0;

    // Directed cases
    start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    finish_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_max_hi_const", Hi, 32'hFFFFFFFE);
    chk("multu_max_lo_const", Lo, 32'h00000001);

    start_op(2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    finish_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 0);
    chk("mult_neg_lo_const", Lo, 32'hFFFFFFEB);

    start_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    finish_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg_lo_const", Lo, 32'hFFFFFFFD);
    chk("div_neg_hi_const", Hi, 32'hFFFFFFFF);

    start_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    finish_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf_lo_const", Lo, 32'h80000000);
    chk("div_ovf_hi_const", Hi, 32'h0);

    do_move(1'b1, 1'b0, 32'h12345678);
    do_move(1'b0, 1'b1, 32'h9ABCDEF0);
    start_op(2'b10, 32'd55, 32'd0, 1'b0, 1'b0);
    finish_op("divu_zero", 2'b10, 32'd55, 32'd0, 0);
    chk("divu_zero_hi_const", Hi, 32'h12345678);
    chk("divu_zero_lo_const", Lo, 32'h9ABCDEF0);

    // Start and Mthi while busy must both be ignored
    start_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'h0000DEAD; B = 32'd3; Mthi = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Mthi = 1'b0;
    finish_op("divu_busy", 2'b10, 32'd100, 32'd7, 5);
    chk("divu_busy_hi_const", Hi, 32'd2);
    chk("divu_busy_lo_const", Lo, 32'd14);
    dcount = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dcount++;
    end
    chk("divu_busy_single_done", dcount, 0);

    // Reset mid-operation abandons it
    start_op(2'b00, 32'h00012345, 32'h00006789, 1'b0, 1'b0);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    mhi = '0; mlo = '0;
    chk1("midrst_busy", Busy, 1'b0);
    chk1("midrst_done", Done, 1'b0);
    chk("midrst_hi", Hi, 32'h0);
    chk("midrst_lo", Lo, 32'h0);
    dcount = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done || Busy) dcount++;
    end
    chk("midrst_quiet", dcount, 0);
    start_op(2'b00, 32'd5, 32'd6, 1'b0, 1'b0);
    finish_op("multu_small", 2'b00, 32'd5, 32'd6, 0);
    chk("multu_small_lo_const", Lo, 32'd30);

    // Start wins over a simultaneous Mtlo
    start_op(2'b00, 32'h11111111, 32'd3, 1'b0, 1'b1);
    finish_op("start_mtlo", 2'b00, 32'h11111111, 32'd3, 0);
    chk("start_mtlo_lo_const", Lo, 32'h33333333);

    // Random operations with occasional moves and boundary operands
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0)
        do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      start_op(rop, ra, rb, 1'b0, 1'b0);
      finish_op("rand", rop, ra, rb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
